// File: rtl/isqrt_shared_arbiter.sv
// Round-robin front end that lets N_REQ requesters share one fixed-latency pipelined isqrt.
// A tag delay line matched to the isqrt latency steers each returning result to its issuer.
module isqrt_shared_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ARG_W   = 32,
  parameter int RES_W   = 16,
  parameter int LATENCY = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hold,
  input  logic [N_REQ-1:0]       req_vld,
  input  logic [N_REQ*ARG_W-1:0] req_arg,
  output logic [N_REQ-1:0]       req_rdy,
  output logic [N_REQ-1:0]       res_vld,
  output logic [RES_W-1:0]       res,
  output logic                   isqrt_x_vld,
  output logic [ARG_W-1:0]       isqrt_x,
  input  logic                   isqrt_y_vld,
  input  logic [RES_W-1:0]       isqrt_y,
  output logic                   busy,
  output logic                   err
);

  localparam int IDX_W = $clog2(N_REQ);

  // Handshake: requester i transfers its argument in any cycle where req_vld[i] & req_rdy[i];
  // req_rdy never depends on anything but ptr, req_vld, hold and rst. Results have no
  // backpressure: res_vld[i] is a one-cycle strobe the requester must capture.

  logic [IDX_W-1:0]   ptr;
  logic [LATENCY-1:0] tag_vld;
  logic [IDX_W-1:0]   tag_idx [LATENCY];
  logic               err_q;

  logic               gnt_any;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   cand;
  logic               t_vld;
  logic [IDX_W-1:0]   t_idx;

  // Scan from ptr upward, wrapping; the first valid requester wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = ptr;
    cand    = ptr;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N_REQ);
      if (!gnt_any && req_vld[cand] && !hold && !rst) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    req_rdy = '0;
    req_rdy[gnt_idx] = gnt_any;
    isqrt_x_vld = gnt_any;
    isqrt_x = req_arg[ARG_W-1:0];
    for (int i = 0; i < N_REQ; i++) begin
      if (IDX_W'(i) == gnt_idx) isqrt_x = req_arg[i*ARG_W +: ARG_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= (gnt_idx == IDX_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Tag line: stage LATENCY-1 holds the tag whose result arrives this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
      for (int s = 0; s < LATENCY; s++) tag_idx[s] <= '0;
    end else begin
      for (int s = LATENCY-1; s >= 1; s--) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_idx[s] <= tag_idx[s-1];
      end
      tag_vld[0] <= gnt_any;
      tag_idx[0] <= gnt_idx;
    end
  end

  assign t_vld = tag_vld[LATENCY-1];
  assign t_idx = tag_idx[LATENCY-1];

  always_comb begin
    res_vld = '0;
    if (!rst && t_vld && isqrt_y_vld) res_vld[t_idx] = 1'b1;
  end

  assign res  = isqrt_y;
  assign busy = (|tag_vld) & ~rst;

  // A result without a tag, or a tag without a result, means the isqrt latency is not what we think.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (t_vld != isqrt_y_vld) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q & ~rst;

endmodule

// File: tb/tb_isqrt_shared_arbiter.sv
// Bench for isqrt_shared_arbiter: an isqrt stub, directed scenarios with literal expectations,
// and a cycle-by-cycle comparison against a queue-based reference model under random traffic.
module tb_isqrt_shared_arbiter;
  localparam int N     = 4;
  localparam int ARG_W = 32;
  localparam int RES_W = 16;
  localparam int L     = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               hold;
  logic [N-1:0]       req_vld;
  logic [N*ARG_W-1:0] req_arg;
  logic [N-1:0]       req_rdy;
  logic [N-1:0]       res_vld;
  logic [RES_W-1:0]   res;
  logic               isqrt_x_vld;
  logic [ARG_W-1:0]   isqrt_x;
  logic               isqrt_y_vld;
  logic [RES_W-1:0]   isqrt_y;
  logic               busy;
  logic               err;
  logic               inject;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  isqrt_shared_arbiter #(.N_REQ(N), .ARG_W(ARG_W), .RES_W(RES_W), .LATENCY(L)) dut (
    .clk(clk), .rst(rst), .hold(hold), .req_vld(req_vld), .req_arg(req_arg),
    .req_rdy(req_rdy), .res_vld(res_vld), .res(res), .isqrt_x_vld(isqrt_x_vld),
    .isqrt_x(isqrt_x), .isqrt_y_vld(isqrt_y_vld), .isqrt_y(isqrt_y), .busy(busy), .err(err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- isqrt stub: LATENCY-cycle pipeline of floor(sqrt(x)) ----------------
  function automatic logic [RES_W-1:0] stub_sqrt(input logic [ARG_W-1:0] x);
    longint r, t;
    r = 0;
    for (int b = RES_W-1; b >= 0; b--) begin
      t = r | (longint'(1) << b);
      if (t * t <= longint'(x)) r = t;
    end
    return RES_W'(r);
  endfunction

  logic             stub_vld [L];
  logic [RES_W-1:0] stub_val [L];
  always @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < L; s++) begin stub_vld[s] <= 1'b0; stub_val[s] <= '0; end
    end else begin
      for (int s = L-1; s >= 1; s--) begin stub_vld[s] <= stub_vld[s-1]; stub_val[s] <= stub_val[s-1]; end
      stub_vld[0] <= isqrt_x_vld;
      stub_val[0] <= stub_sqrt(isqrt_x);
    end
  end
  assign isqrt_y_vld = stub_vld[L-1] | inject;
  assign isqrt_y     = stub_val[L-1];

  // ---------------- check helper ----------------
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int ref_sqrt(input longint x);
    longint r;
    r = longint'($floor($sqrt(real'(x))));
    while (r * r > x) r--;
    while ((r + 1) * (r + 1) <= x) r++;
    return int'(r);
  endfunction

  logic [RES_W-1:0] exp_q [$];
  int               due_q [$];
  int               lane_q[$];
  int               m_ptr = 0;
  bit               m_err = 0;
  int               exp_g;
  bit               ret;
  logic [N-1:0]     exp_rdy;
  logic [N-1:0]     exp_res_vld;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("rst_req_rdy", req_rdy, 0);
      chk("rst_res_vld", res_vld, 0);
      chk("rst_x_vld", isqrt_x_vld, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      exp_q.delete(); due_q.delete(); lane_q.delete();
      m_ptr = 0;
      m_err = 0;
    end else if (rst === 1'b0) begin
      exp_g = -1;
      if (!hold) begin
        for (int k = 0; k < N; k++) begin
          if (exp_g < 0 && req_vld[(m_ptr + k) % N]) exp_g = (m_ptr + k) % N;
        end
      end
      exp_rdy = '0;
      if (exp_g >= 0) exp_rdy[exp_g] = 1'b1;
      chk("req_rdy", req_rdy, exp_rdy);
      chk("x_vld", isqrt_x_vld, exp_g >= 0);
      if (exp_g >= 0) chk("isqrt_x", isqrt_x, req_arg[exp_g*ARG_W +: ARG_W]);

      ret = (due_q.size() > 0) && (due_q[0] == cyc);
      exp_res_vld = '0;
      if (ret && isqrt_y_vld) exp_res_vld[lane_q[0]] = 1'b1;
      chk("res_vld", res_vld, exp_res_vld);
      if (ret && isqrt_y_vld) chk("res", res, exp_q[0]);
      chk("busy", busy, due_q.size() > 0);
      chk("err", err, m_err);

      if (ret != isqrt_y_vld) m_err = 1;
      if (ret) begin void'(exp_q.pop_front()); void'(due_q.pop_front()); void'(lane_q.pop_front()); end
      if (exp_g >= 0) begin
        exp_q.push_back(RES_W'(ref_sqrt(longint'(req_arg[exp_g*ARG_W +: ARG_W]))));
        due_q.push_back(cyc + L);
        lane_q.push_back(exp_g);
        m_ptr = (exp_g + 1) % N;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic set_arg(input int i, input logic [ARG_W-1:0] v);
    req_arg[i*ARG_W +: ARG_W] = v;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seen;
    rst = 1'b1; hold = 1'b0; req_vld = '0; req_arg = '0; inject = 1'b0;
    #1;
    do_reset(3);

    // 1: single request on lane 2
    req_vld = 4'b0100; set_arg(2, 81);
    @(negedge clk);
    chk("t1_req_rdy", req_rdy, 4'b0100);
    chk("t1_isqrt_x", isqrt_x, 81);
    tick(); req_vld = '0;
    repeat (L-1) tick();
    @(negedge clk);
    chk("t1_res_vld", res_vld, 4'b0100);
    chk("t1_res", res, 9);
    tick();

    // 2: all lanes valid for 8 cycles after a fresh reset
    do_reset(2);
    for (int i = 0; i < N; i++) set_arg(i, i * i);
    req_vld = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t2_grant", req_rdy, 4'b0001 << (k % 4));
      tick();
    end
    req_vld = '0;
    seen = 0;
    for (int k = 0; k < 3*L && !seen; k++) begin
      @(negedge clk);
      if (res_vld != 0) seen = 1; else tick();
    end
    chk("t2_results_arrived", seen, 1);
    if (seen) begin
      for (int k = 0; k < 8; k++) begin
        if (k > 0) begin tick(); @(negedge clk); end
        chk("t2_res_lane", res_vld, 4'b0001 << (k % 4));
        chk("t2_res_val", res, k % 4);
      end
    end
    tick();

    // 3: one grant, then hold with all lanes requesting
    req_vld = 4'b1111;
    @(negedge clk);
    chk("t3_pre_grant", isqrt_x_vld, 1);
    tick(); hold = 1'b1;
    for (int k = 0; k <= L; k++) begin
      @(negedge clk);
      chk("t3_hold_rdy", req_rdy, 0);
      chk("t3_hold_xvld", isqrt_x_vld, 0);
      if (k == L-1) chk("t3_busy_last", busy, 1);
      if (k == L) chk("t3_busy_drop", busy, 0);
      tick();
    end
    hold = 1'b0; req_vld = '0;

    // 4: reset 3 cycles after issuing 144
    set_arg(0, 144); req_vld = 4'b0001;
    tick(); req_vld = '0;
    repeat (3) tick();
    do_reset(1);
    seen = 0;
    for (int k = 0; k < 2*L; k++) begin
      @(negedge clk);
      if (res_vld != 0) seen = 1;
      tick();
    end
    chk("t4_no_res", seen, 0);
    @(negedge clk);
    chk("t4_busy", busy, 0);
    chk("t4_err", err, 0);
    tick();

    // 5: spurious isqrt_y_vld with an empty tag line
    inject = 1'b1;
    @(negedge clk);
    chk("t5_res_vld_inj", res_vld, 0);
    tick(); inject = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5_err_sticky", err, 1);
      chk("t5_res_vld", res_vld, 0);
      tick();
    end

    // 6: random traffic against the model
    do_reset(2);
    for (int k = 0; k < 500; k++) begin
      req_vld = N'($urandom_range(0, (1 << N) - 1));
      hold = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 2))
          0: set_arg(i, $urandom_range(0, 1000));
          1: set_arg(i, $urandom());
          default: set_arg(i, 32'hFFFF_FFFF - $urandom_range(0, 3));
        endcase
      end
      tick();
    end
    req_vld = '0; hold = 1'b0;
    seen = 0;
    for (int k = 0; k < 4*L && !seen; k++) begin
      @(negedge clk);
      if (!busy) seen = 1; else tick();
    end
    chk("t6_drained", seen, 1);
    chk("t6_model_empty", due_q.size(), 0);
    chk("t6_err", err, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout at cycle %0d: got running expected finished", cyc);
    $fatal(1);
  end
endmodule
